// File: rtl/board_pkg.sv
// board_pkg: shared constants and types for the PacMan tile-map board.
//   MAZE_COLS / MAZE_ROWS : board dimensions in tiles
//   MAZE                  : wall map, MAZE[row][col] = 1 for a wall tile
//   PELLET_TOTAL          : number of open tiles (pellets after a reload)
//   board_state_t         : board FSM states
package board_pkg;

   localparam int unsigned MAZE_COLS = 28;
   localparam int unsigned MAZE_ROWS = 31;

   typedef logic [MAZE_ROWS-1:0][MAZE_COLS-1:0] maze_t;

   // Row templates; bit 0 is column 0. All rows are left/right symmetric.
   localparam logic [MAZE_COLS-1:0] ROW_SOLID = 28'hFFFFFFF;  // 0 open tiles
   localparam logic [MAZE_COLS-1:0] ROW_OPEN  = 28'h8000001;  // 26 open tiles
   localparam logic [MAZE_COLS-1:0] ROW_BARS  = 28'hBDF6FBD;  // 6 open tiles

   // Row 30 first (MSB). Odd rows are open corridors, even inner rows carry bars.
   localparam maze_t MAZE = {ROW_SOLID, {14{ROW_OPEN, ROW_BARS}}, ROW_OPEN, ROW_SOLID};

   function automatic int unsigned count_open(input maze_t m);
      int unsigned n;
      n = 0;
      for (int r = 0; r < int'(MAZE_ROWS); r++) begin
         for (int c = 0; c < int'(MAZE_COLS); c++) begin
            if (!m[r][c]) n++;
         end
      end
      return n;
   endfunction

   localparam int unsigned PELLET_TOTAL = count_open(MAZE);

   typedef enum logic [1:0] {
      INIT = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } board_state_t;

endpackage

// File: rtl/board_flash_timer.sv
// board_flash_timer: game-over wall flasher.
// Counts frame_start pulses while enabled and toggles o_flash_lit every
// FLASH_FRAMES pulses. i_clear forces the counter to 0 and the output lit.
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_enable         : count frame pulses
//   i_clear          : restart the flash phase (lit, count 0)
//   i_frame_start    : one-cycle pulse per video frame
//   o_flash_lit      : walls are drawn when 1
module board_flash_timer
   import board_pkg::*;
#(
   parameter int unsigned FLASH_FRAMES = 16
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_enable,
   input  logic i_clear,
   input  logic i_frame_start,
   output logic o_flash_lit
);

   localparam int unsigned CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FLASH_FRAMES - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_lit;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_cnt <= '0;
         r_lit <= 1'b1;
      end else if (i_clear) begin
         r_cnt <= '0;
         r_lit <= 1'b1;
      end else if (i_enable && i_frame_start) begin
         if (r_cnt == CNT_MAX) begin
            r_cnt <= '0;
            r_lit <= ~r_lit;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_flash_lit = r_lit;

endmodule

// File: rtl/board_tile_map.sv
// board_tile_map: tile-map playfield with per-tile pellet storage.
// Maps the VGA pixel (x, y) onto a ROWS x COLS tile grid and reports wall and
// pellet coverage two cycles later. Pellets are reloaded by an INIT sweep and
// cleared by the game logic through a valid/ready eat handshake.
//   i_clk, i_reset_n         : clock, asynchronous active-low reset
//   i_frame_start            : one-cycle pulse per video frame
//   i_gameover               : level, enters OVER from PLAY
//   i_restart                : pulse, reload pellets and re-enter INIT
//   i_x, i_y                 : current pixel column / row
//   i_eat_valid/col/row      : eat request; o_eat_ready accepts it
//   o_wall_on, o_pellet_on   : pixel coverage (2-cycle latency)
//   o_pellets_left           : remaining pellets
//   o_board_clear            : PLAY with no pellets left (registered)
module board_tile_map
   import board_pkg::*;
#(
   parameter int unsigned TILE         = 8,
   parameter int unsigned COLS         = 28,
   parameter int unsigned ROWS         = 31,
   parameter int unsigned X_OFS        = 208,
   parameter int unsigned Y_OFS        = 116,
   parameter int unsigned FLASH_FRAMES = 16
) (
   input  logic                           i_clk,
   input  logic                           i_reset_n,
   input  logic                           i_frame_start,
   input  logic                           i_gameover,
   input  logic                           i_restart,
   input  logic [9:0]                     i_x,
   input  logic [8:0]                     i_y,
   input  logic                           i_eat_valid,
   input  logic [$clog2(COLS)-1:0]        i_eat_col,
   input  logic [$clog2(ROWS)-1:0]        i_eat_row,
   output logic                           o_eat_ready,
   output logic                           o_wall_on,
   output logic                           o_pellet_on,
   output logic [$clog2(ROWS*COLS+1)-1:0] o_pellets_left,
   output logic                           o_board_clear
);

   localparam int unsigned TB  = $clog2(TILE);
   localparam int unsigned CIW = $clog2(COLS);
   localparam int unsigned RIW = $clog2(ROWS);
   localparam int unsigned CW  = $clog2(ROWS * COLS + 1);

   localparam logic signed [10:0] BX_LIM  = 11'(COLS * TILE);
   localparam logic signed [9:0]  BY_LIM  = 10'(ROWS * TILE);
   localparam logic [TB-1:0]      OFS_LO  = TB'(TILE / 2 - 1);
   localparam logic [TB-1:0]      OFS_HI  = TB'(TILE / 2);
   localparam logic [CIW-1:0]     COL_MAX = CIW'(COLS - 1);
   localparam logic [RIW-1:0]     ROW_MAX = RIW'(ROWS - 1);

   board_state_t r_state, w_state_next;

   logic [ROWS-1:0][COLS-1:0] r_pellet;
   logic [RIW-1:0]            r_swp_row;
   logic [CIW-1:0]            r_swp_col;
   logic [CW-1:0]             r_pellets_left;
   logic                      r_board_clear;

   logic                      w_swp_last;
   logic                      w_swp_open;
   logic                      w_eat_ready;
   logic                      w_eat_in_range;
   logic                      w_eat_hit;
   logic                      w_flash_lit;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= INIT;
      else            r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (i_restart) begin
         w_state_next = INIT;
      end else begin
         unique case (r_state)
            INIT:    if (w_swp_last) w_state_next = PLAY;
            PLAY:    if (i_gameover) w_state_next = OVER;
            OVER:    w_state_next = OVER;  // only restart leaves OVER
            default: w_state_next = INIT;
         endcase
      end
   end

   // ------------------------------------------------ pellet store / count
   assign w_swp_last  = (r_swp_row == ROW_MAX) && (r_swp_col == COL_MAX);
   assign w_swp_open  = ~MAZE[r_swp_row][r_swp_col];

   assign w_eat_ready    = (r_state == PLAY) && !i_restart;
   assign w_eat_in_range = (32'(i_eat_row) < ROWS) && (32'(i_eat_col) < COLS);
   // Out-of-range requests are still accepted; the range term just masks them.
   assign w_eat_hit      = i_eat_valid && w_eat_ready && w_eat_in_range &&
                           r_pellet[i_eat_row][i_eat_col];

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_pellet       <= '0;
         r_swp_row      <= '0;
         r_swp_col      <= '0;
         r_pellets_left <= '0;
      end else if (i_restart) begin
         r_swp_row      <= '0;
         r_swp_col      <= '0;
         r_pellets_left <= '0;
      end else if (r_state == INIT) begin
         r_pellet[r_swp_row][r_swp_col] <= w_swp_open;
         r_pellets_left                 <= r_pellets_left + CW'(w_swp_open);
         if (r_swp_col == COL_MAX) begin
            r_swp_col <= '0;
            r_swp_row <= w_swp_last ? '0 : r_swp_row + 1'b1;
         end else begin
            r_swp_col <= r_swp_col + 1'b1;
         end
      end else if (w_eat_hit) begin
         r_pellet[i_eat_row][i_eat_col] <= 1'b0;
         if (r_pellets_left != '0) r_pellets_left <= r_pellets_left - 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_board_clear <= 1'b0;
      else            r_board_clear <= (r_state == PLAY) && (r_pellets_left == '0);
   end

   // -------------------------------------------------------------- flash
   board_flash_timer #(
      .FLASH_FRAMES (FLASH_FRAMES)
   ) u_flash (
      .i_clk         (i_clk),
      .i_reset_n     (i_reset_n),
      .i_enable      (r_state == OVER),
      .i_clear       (r_state != OVER),
      .i_frame_start (i_frame_start),
      .o_flash_lit   (w_flash_lit)
   );

   // --------------------------------------------------------- pixel path
   // One bit wider and signed so pixels left of / above the board go negative.
   logic signed [10:0] w_bx;
   logic signed [9:0]  w_by;
   logic               w_in_board;
   logic               w_mid;

   assign w_bx = $signed({1'b0, i_x}) - $signed(11'(X_OFS));
   assign w_by = $signed({1'b0, i_y}) - $signed(10'(Y_OFS));

   assign w_in_board = (w_bx >= 11'sd0) && (w_bx < BX_LIM) &&
                       (w_by >= 10'sd0) && (w_by < BY_LIM);
   assign w_mid      = ((w_bx[TB-1:0] == OFS_LO) || (w_bx[TB-1:0] == OFS_HI)) &&
                       ((w_by[TB-1:0] == OFS_LO) || (w_by[TB-1:0] == OFS_HI));

   logic [RIW-1:0] r_s1_row;
   logic [CIW-1:0] r_s1_col;
   logic           r_s1_mid;
   logic           r_s1_in;
   logic           r_wall_on;
   logic           r_pellet_on;

   // Stage 1: tile index (zeroed outside the board so stage 2 never indexes
   // past the array), offset flag, in-board flag.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_s1_row <= '0;
         r_s1_col <= '0;
         r_s1_mid <= 1'b0;
         r_s1_in  <= 1'b0;
      end else begin
         r_s1_row <= w_in_board ? w_by[TB +: RIW] : '0;
         r_s1_col <= w_in_board ? w_bx[TB +: CIW] : '0;
         r_s1_mid <= w_mid;
         r_s1_in  <= w_in_board;
      end
   end

   // Stage 2 reads r_pellet before any eat on the same edge lands.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wall_on   <= 1'b0;
         r_pellet_on <= 1'b0;
      end else begin
         r_wall_on   <= r_s1_in && MAZE[r_s1_row][r_s1_col] && w_flash_lit;
         r_pellet_on <= r_s1_in && r_s1_mid && r_pellet[r_s1_row][r_s1_col] &&
                        (r_state == PLAY);
      end
   end

   assign o_eat_ready    = w_eat_ready;
   assign o_wall_on      = r_wall_on;
   assign o_pellet_on    = r_pellet_on;
   assign o_pellets_left = r_pellets_left;
   assign o_board_clear  = r_board_clear;

endmodule

// File: tb/tb_board_tile_map.sv
// tb_board_tile_map: directed self-checking bench for board_tile_map.
// Wall map used for expectations: rows 0/30 solid; odd rows open except the
// border (26 pellets); even inner rows have 6 gaps. 474 pellets in total.
module tb_board_tile_map;

   localparam int unsigned TOTAL = 474;

   logic       clk;
   logic       reset_n;
   logic       frame_start;
   logic       gameover;
   logic       restart;
   logic [9:0] x;
   logic [8:0] y;
   logic       eat_valid;
   logic [4:0] eat_col;
   logic [4:0] eat_row;
   logic       eat_ready;
   logic       wall_on;
   logic       pellet_on;
   logic [9:0] pellets_left;
   logic       board_clear;

   int n_tests = 0;
   int n_fail  = 0;

   board_tile_map dut (
      .i_clk          (clk),
      .i_reset_n      (reset_n),
      .i_frame_start  (frame_start),
      .i_gameover     (gameover),
      .i_restart      (restart),
      .i_x            (x),
      .i_y            (y),
      .i_eat_valid    (eat_valid),
      .i_eat_col      (eat_col),
      .i_eat_row      (eat_row),
      .o_eat_ready    (eat_ready),
      .o_wall_on      (wall_on),
      .o_pellet_on    (pellet_on),
      .o_pellets_left (pellets_left),
      .o_board_clear  (board_clear)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pix(input int px, input int py);
      x = 10'(px);
      y = 9'(py);
      step(2);
   endtask

   task automatic eat(input int r, input int c);
      eat_row   = 5'(r);
      eat_col   = 5'(c);
      eat_valid = 1'b1;
      step(1);
      eat_valid = 1'b0;
   endtask

   task automatic pulses(input int n);
      repeat (n) begin
         frame_start = 1'b1;
         step(1);
         frame_start = 1'b0;
         step(1);
      end
   endtask

   initial begin
      reset_n = 1'b0; frame_start = 1'b0; gameover = 1'b0; restart = 1'b0;
      x = '0; y = '0; eat_valid = 1'b0; eat_col = '0; eat_row = '0;
      step(3);
      check("rst_ready", eat_ready, 0);
      check("rst_wall", wall_on, 0);
      check("rst_pellet", pellet_on, 0);
      check("rst_left", pellets_left, 0);
      check("rst_clear", board_clear, 0);

      // INIT sweep: 868 cycles before eats are accepted
      reset_n = 1'b1;
      check("init_ready", eat_ready, 0);
      for (int i = 0; i < 867; i++) begin
         step(1);
         check("init_ready", eat_ready, 0);
      end
      step(1);
      check("play_ready", eat_ready, 1);
      check("play_left", pellets_left, TOTAL);
      check("play_clear", board_clear, 0);

      // Pixel path
      pix(208, 116); check("corner_wall", wall_on, 1); check("corner_pel", pellet_on, 0);
      pix(219, 127); check("t11_pel", pellet_on, 1); check("t11_wall", wall_on, 0);
      pix(217, 127); check("t11_offpel", pellet_on, 0);
      pix(219, 127);

      // Eat (1,1): pixel sees pre-eat value on the accepting edge
      eat_row = 5'd1; eat_col = 5'd1; eat_valid = 1'b1;
      check("eat_ready", eat_ready, 1);
      step(1);
      eat_valid = 1'b0;
      check("eat_left", pellets_left, TOTAL - 1);
      check("eat_pre_pel", pellet_on, 1);
      step(1);
      check("eat_post_pel", pellet_on, 0);
      eat(1, 1);   check("eat_again", pellets_left, TOTAL - 1);
      eat(0, 0);   check("eat_wall", pellets_left, TOTAL - 1);
      eat(31, 31); check("eat_oor", pellets_left, TOTAL - 1);
      check("eat_clear", board_clear, 0);

      // Board boundaries
      pix(0, 0);     check("out0_wall", wall_on, 0); check("out0_pel", pellet_on, 0);
      pix(639, 479); check("outm_wall", wall_on, 0); check("outm_pel", pellet_on, 0);
      pix(207, 116); check("left_edge", wall_on, 0);
      pix(431, 116); check("right_in", wall_on, 1);
      pix(432, 116); check("right_out", wall_on, 0);
      pix(208, 363); check("bottom_in", wall_on, 1);
      pix(208, 364); check("bottom_out", wall_on, 0);

      // Game over: pellets hidden, eats refused, walls flash
      pix(227, 127); check("t12_pel", pellet_on, 1);
      gameover = 1'b1;
      step(1);
      check("over_ready", eat_ready, 0);
      step(2);
      check("over_pel", pellet_on, 0);
      eat(1, 2);
      check("over_eat", pellets_left, TOTAL - 1);
      pix(208, 116); check("over_wall", wall_on, 1);
      pulses(15); step(2); check("flash_15", wall_on, 1);
      pulses(1);  step(2); check("flash_16", wall_on, 0);
      gameover = 1'b0;
      step(1);
      check("over_hold", eat_ready, 0);
      pulses(16); step(2); check("flash_32", wall_on, 1);
      pix(227, 127); check("over_pel2", pellet_on, 0);

      // Restart beats a simultaneous eat
      restart = 1'b1; eat_valid = 1'b1; eat_row = 5'd1; eat_col = 5'd2;
      check("rs_ready", eat_ready, 0);
      step(1);
      restart = 1'b0; eat_valid = 1'b0;
      check("rs_left", pellets_left, 0);
      for (int i = 0; i < 867; i++) begin
         step(1);
         check("rs_init_ready", eat_ready, 0);
      end
      step(1);
      check("rs_play_ready", eat_ready, 1);
      check("rs_left_full", pellets_left, TOTAL);
      step(2);
      check("rs_t12_pel", pellet_on, 1);
      pix(219, 127); check("rs_t11_pel", pellet_on, 1);

      // Clear the board, last pellet at (29,26)
      for (int r = 0; r < 31; r++) begin
         for (int c = 0; c < 28; c++) begin
            if (!(r == 29 && c == 26)) eat(r, c);
         end
      end
      check("clr_left1", pellets_left, 1);
      check("clr_clear0", board_clear, 0);
      eat(29, 26);
      check("clr_left0", pellets_left, 0);
      check("clr_lag", board_clear, 0);
      step(1);
      check("clr_set", board_clear, 1);
      eat(29, 26);
      check("clr_no_uflow", pellets_left, 0);

      // Asynchronous reset in the middle of INIT
      x = 10'd208; y = 9'd116;
      restart = 1'b1;
      step(1);
      restart = 1'b0;
      step(100);
      check("mid_left", pellets_left, 47);
      check("mid_wall", wall_on, 1);
      #2 reset_n = 1'b0;
      #1;
      check("arst_wall", wall_on, 0);
      check("arst_pel", pellet_on, 0);
      check("arst_ready", eat_ready, 0);
      check("arst_left", pellets_left, 0);
      check("arst_clear", board_clear, 0);
      step(1);
      reset_n = 1'b1;
      step(1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
